// File: rtl/norm_pkg.sv
// Shared widths, constants and helpers for the FP add/sub post-adder normaliser.
package norm_pkg;

  localparam int MAN_W_DEF = 24;
  localparam int EXP_W_DEF = 8;
  localparam int EXP_MAX   = (1 << EXP_W_DEF) - 1;

  typedef struct packed {
    logic zero;
    logic uf;
    logic of;
  } norm_flags_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/norm_lzc.sv
// Priority leading-zero counter; an all-zero input reports MAN_W.
module norm_lzc
  import norm_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int LZC_W = clog2(MAN_W + 1)
) (
  input  logic [MAN_W-1:0] mant,
  output logic [LZC_W-1:0] lzc
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    lzc = LZC_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (mant[i]) lzc = LZC_W'(MAN_W - 1 - i);
    end
  end

endmodule

// File: rtl/norm_pipe.sv
// Two-stage normaliser: stage A captures the sum and its leading-zero count,
// stage B shifts and adjusts the exponent (carry, underflow, overflow).
module norm_pipe
  import norm_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W:0]   in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_uf,
  output logic             out_of
);

  localparam int LZC_W = clog2(MAN_W + 1);
  localparam int XW    = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 1;
  localparam logic [EXP_W:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};

  logic             va_reg;
  logic [MAN_W:0]   a_mant_reg;
  logic [EXP_W-1:0] a_exp_reg;
  logic             a_carry_reg;
  logic             a_zero_reg;
  logic [LZC_W-1:0] a_lzc_reg;
  logic [LZC_W-1:0] lzc_next;

  logic adv_a, adv_b, accept;

  assign adv_b    = !out_valid || out_ready;
  assign adv_a    = !va_reg || adv_b;
  assign in_ready = adv_a;
  assign accept   = in_valid && in_ready;

  norm_lzc #(.MAN_W(MAN_W), .LZC_W(LZC_W)) u_lzc (
    .mant (in_mant[MAN_W-1:0]),
    .lzc  (lzc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_reg      <= 1'b0;
      a_mant_reg  <= '0;
      a_exp_reg   <= '0;
      a_carry_reg <= 1'b0;
      a_zero_reg  <= 1'b0;
      a_lzc_reg   <= '0;
    end else if (adv_a) begin
      va_reg <= in_valid;
      if (accept) begin
        a_mant_reg  <= in_mant;
        a_exp_reg   <= in_exp;
        a_carry_reg <= in_mant[MAN_W];
        a_zero_reg  <= (in_mant == '0);
        a_lzc_reg   <= lzc_next;
      end
    end
  end

  // Exponent math is widened so neither increment nor subtract can wrap.
  logic [EXP_W:0]   exp_inc;
  logic [XW-1:0]    exp_x, lzc_x;
  logic [LZC_W-1:0] uf_shift;

  assign exp_inc  = {1'b0, a_exp_reg} + (EXP_W + 1)'(1);
  assign exp_x    = XW'(a_exp_reg);
  assign lzc_x    = XW'(a_lzc_reg);
  assign uf_shift = (a_exp_reg == '0) ? '0 : LZC_W'(exp_x - XW'(1));

  logic [MAN_W-1:0] b_mant_next;
  logic [EXP_W-1:0] b_exp_next;
  norm_flags_t      b_flags_next;

  always_comb begin
    b_mant_next  = '0;
    b_exp_next   = '0;
    b_flags_next = '0;
    if (a_zero_reg) begin
      b_flags_next.zero = 1'b1;
    end else if (a_carry_reg) begin
      if (exp_inc >= EXP_ONES) begin
        b_exp_next      = '1;
        b_flags_next.of = 1'b1;
      end else begin
        b_mant_next = a_mant_reg[MAN_W:1];
        b_exp_next  = exp_inc[EXP_W-1:0];
      end
    end else if (lzc_x < exp_x) begin
      b_mant_next = a_mant_reg[MAN_W-1:0] << a_lzc_reg;
      b_exp_next  = EXP_W'(exp_x - lzc_x);
    end else begin
      // Shift only as far as exponent 1 allows, then encode as denormal.
      b_mant_next     = a_mant_reg[MAN_W-1:0] << uf_shift;
      b_flags_next.uf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uf    <= 1'b0;
      out_of    <= 1'b0;
    end else if (adv_b) begin
      out_valid <= va_reg;
      if (va_reg) begin
        out_mant <= b_mant_next;
        out_exp  <= b_exp_next;
        out_zero <= b_flags_next.zero;
        out_uf   <= b_flags_next.uf;
        out_of   <= b_flags_next.of;
      end
    end
  end

endmodule

// File: tb/tb_norm_pipe.sv
// Scoreboard bench for norm_pipe (MAN_W=24, EXP_W=8): directed vectors, stalled stream, mid-flight reset.
module tb_norm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero, out_uf, out_of;

  typedef struct packed {
    logic [23:0] m;
    logic [7:0]  e;
    logic [2:0]  f;   // {zero, uf, of}
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   ready_toggle = 1'b0;
  int   tog_idx = 0;
  logic [3:0] ready_pat = 4'b1001;

  norm_pipe #(.MAN_W(24), .EXP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_uf    (out_uf),
    .out_of    (out_of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic res_t model(input logic [24:0] m, input logic [7:0] e);
    res_t r;
    int lz;
    int sh;
    logic [23:0] t;
    r  = '0;
    lz = 24;
    for (int i = 0; i < 24; i++) if (m[i]) lz = 23 - i;
    if (m == '0) begin
      r.f = 3'b100;
    end else if (m[24]) begin
      if (int'(e) + 1 >= 255) begin
        r.e = 8'hFF;
        r.f = 3'b001;
      end else begin
        r.m = m[24:1];
        r.e = 8'(int'(e) + 1);
      end
    end else if (lz < int'(e)) begin
      t   = m[23:0] << lz;
      r.m = t;
      r.e = 8'(int'(e) - lz);
    end else begin
      sh  = (e == 0) ? 0 : int'(e) - 1;
      t   = m[23:0] << sh;
      r.m = t;
      r.f = 3'b010;
    end
    return r;
  endfunction

  // Monitor: occupancy-based in_ready check, then compare head of scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 64'(in_ready), 64'(!(sb.size() == 2 && !out_ready)));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("out_mant", 64'(out_mant), 64'(sb[0].m));
          check("out_exp", 64'(out_exp), 64'(sb[0].e));
          check("out_flags", 64'({out_zero, out_uf, out_of}), 64'(sb[0].f));
          if (out_ready) begin
            $display("out mant=%h exp=%0d zero=%b uf=%b of=%b", out_mant, out_exp, out_zero, out_uf, out_of);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) begin
        out_ready = ready_pat[tog_idx % 4];
        tog_idx++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [24:0] m, input logic [7:0] e, input res_t want);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(want);
      $display("in  mant=%h exp=%0d", m, e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_lat(input logic [24:0] m, input logic [7:0] e, input res_t want);
    send(m, e, want);
    @(posedge clk);
    #1 check("latency", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] m;
    logic [7:0]  e;
    int w;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_mant", 64'(out_mant), 64'd0);
    check("rst_out_exp", 64'(out_exp), 64'd0);
    check("rst_out_flags", 64'({out_zero, out_uf, out_of}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("in_ready_after_rst", 64'(in_ready), 64'd1);

    send_lat(25'h0_800000, 8'd127, res_t'{24'h800000, 8'd127, 3'b000});
    send_lat(25'h0_001000, 8'd100, res_t'{24'h800000, 8'd89,  3'b000});
    send_lat(25'h1_800001, 8'd200, res_t'{24'hC00000, 8'd201, 3'b000});
    send_lat(25'h1_800001, 8'd254, res_t'{24'h000000, 8'd255, 3'b001});
    send_lat(25'h0_000100, 8'd5,   res_t'{24'h001000, 8'd0,   3'b010});
    send_lat(25'h0_000000, 8'd77,  res_t'{24'h000000, 8'd0,   3'b100});
    send_lat(25'h0_000001, 8'd0,   res_t'{24'h000001, 8'd0,   3'b010});
    send_lat(25'h1_FFFFFF, 8'd253, res_t'{24'hFFFFFF, 8'd254, 3'b000});

    // Back-to-back stream with out_ready cycling 1,0,0,1.
    ready_toggle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m = 25'h0_400000 >> i;
      e = 8'(20 + 3 * i);
      send(m, e, model(m, e));
    end
    for (int i = 0; i < 24; i++) begin
      m = 25'($urandom) >> $urandom_range(0, 25);
      e = 8'($urandom);
      send(m, e, model(m, e));
    end
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1 check("drain", 64'(sb.size()), 64'd0);
    ready_toggle = 1'b0;
    out_ready = 1'b0;

    // Two beats in flight, then a one-cycle reset.
    send(25'h0_123456, 8'd50, model(25'h0_123456, 8'd50));
    send(25'h1_000002, 8'd10, model(25'h1_000002, 8'd10));
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_mant", 64'(out_mant), 64'd0);
    check("midrst_out_exp", 64'(out_exp), 64'd0);
    check("midrst_out_flags", 64'({out_zero, out_uf, out_of}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_no_replay", 64'(out_valid), 64'd0);
    send_lat(25'h0_0F0000, 8'd30, res_t'{24'hF00000, 8'd26, 3'b000});

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1 check("final_drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_pipe.md
Name: norm_pipe

Overview:
- Parametrised, 2-stage pipelined normaliser for the floating-point add/sub datapath.
- Sits between the mantissa adder and the packer.
- Handles three cases the combinational normaliser does not:
  - adder carry-out (right shift by 1);
  - exponent underflow to denormal;
  - exponent overflow to infinity.
- Uses valid/ready flow control at 1 result per cycle.

Parameters:
- MAN_W, 24, mantissa width including hidden bit.
- EXP_W, 8, biased exponent width.
- LZC_W, $clog2(MAN_W+1), width of the leading-zero count (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_mant  in  MAN_W+1  raw adder sum; bit MAN_W is carry-out.
- in_exp  in  EXP_W  biased exponent of the larger operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_mant  out  MAN_W  normalised mantissa (hidden bit at MAN_W-1 unless denormal or zero).
- out_exp  out  EXP_W  adjusted biased exponent.
- out_zero  out  1  result is exactly zero.
- out_uf  out  1  result underflowed to denormal (exp 0, mant nonzero).
- out_of  out  1  result overflowed (exp all-ones, mant 0).

Behaviour:
- Reset: stage-A valid, stage-B valid, out_valid and all out_* registers go to 0. in_ready is 1 one cycle after rst deasserts.
- Reset mid-operation discards in-flight beats; nothing is replayed.
- Stage A, on accept (in_valid && in_ready):
  - registers mant, exp, carry = in_mant[MAN_W], zero = (in_mant==0);
  - registers lzc = leading zeros of in_mant[MAN_W-1:0], range 0..MAN_W; all-zero gives MAN_W.
- Stage B computes from the stage-A registers, in priority order:
  - zero: out_mant=0, out_exp=0, out_zero=1, uf=of=0.
  - carry: out_mant=mant[MAN_W:1] (LSB truncated, no rounding); e=exp+1.
    - If e >= 2^EXP_W-1: out_exp=all-ones, out_mant=0, out_of=1.
    - Else out_exp=e.
  - lzc < exp: out_mant=mant<<lzc, out_exp=exp-lzc.
  - lzc >= exp: shift = (exp==0) ? 0 : exp-1; out_mant=mant<<shift, out_exp=0, out_uf=1.
- Exponent arithmetic is done at EXP_W+1 bits; there is no silent wrap-around.
- Latency and throughput:
  - Exactly 2 cycles from accept to out_valid with no stalls.
  - Throughput 1 beat/cycle while out_ready=1.
- Handshake:
  - Stage B advances when !out_valid || out_ready.
  - Stage A advances when !vA || stage B advances.
  - in_ready = !vA || stage B advances. This is a combinational path from out_ready.
- out_* hold stable while out_valid && !out_ready.
- in_valid may drop without an accept; this has no side effect.
- Simultaneous accept and drain with both stages full passes through with no bubble.
- Stall with both stages full: in_ready=0. No beat is lost or duplicated.

Decomposition:
- Package norm_pkg holds:
  - MAN_W/EXP_W defaults;
  - the EXP_MAX constant (all-ones);
  - a flags typedef {zero, uf, of};
  - a clog2 helper function.
- One sub-module, norm_lzc: parametrised priority leading-zero counter, combinational, MAN_W-bit input, LZC_W-bit output. It replaces the fixed 24-way mux chain.
- Shifter and exponent logic stay inline in norm_pipe.

Test Plan (MAN_W=24, EXP_W=8):
- in_mant=25'h0_800000, in_exp=8'd127, out_ready=1 -> after 2 cycles out_mant=24'h800000, out_exp=127, all flags 0.
- in_mant=25'h0_001000 (lzc 11), in_exp=100 -> out_mant=24'h800000, out_exp=89.
- in_mant=25'h1_800001, in_exp=200 -> out_mant=24'hC00000, out_exp=201. Same mant with in_exp=254 -> out_exp=255, out_mant=0, out_of=1.
- in_mant=25'h0_000100 (lzc 15), in_exp=5 -> out_exp=0, out_mant=24'h001000 (shift 4), out_uf=1. in_mant=0, in_exp=77 -> out_zero=1, out_exp=0.
- Back-to-back stream of 8 beats with out_ready toggled 1,0,0,1,…:
  - results arrive in order, none dropped or duplicated;
  - out_* stable during stalls;
  - in_ready=0 only while both stages are full and out_ready=0.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and all outputs 0 immediately. The next accepted beat appears 2 cycles after accept.
